dateinfo_seq: RTL

- Sequencer that owns the three-phase date-info pipeline (`dateinfo_2`).
- It takes a BCD date/month/year snapshot, either from an explicit request or automatically when the DS1302 snapshot changes, and range-checks it.
- It feeds the pipeline date, then month, then year on consecutive `ena` cycles, then captures day-of-week, leap-year and days-in-month into result registers with an error code.
- Sits between the DS1302 readout registers and the display/calendar logic.

---
 rtl/dateinfo_seq.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dateinfo_seq.sv
// Sequencer for the three-phase date-info pipeline: it snapshots a BCD date, feeds
// date/month/year on consecutive enable cycles and captures the pipeline results.
module dateinfo_seq #(
   parameter bit CHECK_RANGE = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req,
   input  logic       auto_en,
   input  logic [7:0] date_in,
   input  logic [7:0] month_in,
   input  logic [7:0] year_in,
   output logic       dinfo_ena,
   output logic [7:0] dinfo_data,
   input  logic [2:0] dinfo_day,
   input  logic       dinfo_leap,
   input  logic [7:0] dinfo_dim,
   output logic       busy,
   output logic       done,
   output logic [1:0] err,
   output logic [2:0] day,
   output logic       leap_year,
   output logic [7:0] days_in_month
);

   typedef enum logic [2:0] {IDLE, FEED_D, FEED_M, FEED_Y, CAPTURE} state_t;

   state_t     state;
   logic [7:0] snap_date, snap_month, snap_year;
   logic [7:0] last_date, last_month, last_year;
   logic       start;
   logic       bad_in;

   function automatic logic malformed(input logic [7:0] d, input logic [7:0] m,
                                      input logic [7:0] y);
      logic nib_bad;
      nib_bad = (d[7:4] > 4'd9) || (d[3:0] > 4'd9) ||
                (m[7:4] > 4'd9) || (m[3:0] > 4'd9) ||
                (y[7:4] > 4'd9) || (y[3:0] > 4'd9);
      return nib_bad || (m < 8'h01) || (m > 8'h12) || (d < 8'h01) || (d > 8'h31);
   endfunction

   // Last-processed registers reset to FF so the first auto compare always differs.
   always_comb begin
      start  = req || (auto_en &&
               ({date_in, month_in, year_in} != {last_date, last_month, last_year}));
      bad_in = CHECK_RANGE && malformed(date_in, month_in, year_in);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         dinfo_ena     <= 1'b0;
         dinfo_data    <= 8'h00;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 2'b00;
         day           <= 3'd0;
         leap_year     <= 1'b0;
         days_in_month <= 8'h00;
         snap_date     <= 8'h00;
         snap_month    <= 8'h00;
         snap_year     <= 8'h00;
         last_date     <= 8'hFF;
         last_month    <= 8'hFF;
         last_year     <= 8'hFF;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  snap_date  <= date_in;
                  snap_month <= month_in;
                  snap_year  <= year_in;
                  if (bad_in) begin
                     done       <= 1'b1;
                     err        <= 2'b01;
                     last_date  <= date_in;
                     last_month <= month_in;
                     last_year  <= year_in;
                  end else begin
                     state      <= FEED_D;
                     busy       <= 1'b1;
                     dinfo_ena  <= 1'b1;
                     dinfo_data <= date_in;
                  end
               end
            end
            FEED_D: begin
               dinfo_data <= snap_month;
               state      <= FEED_M;
            end
            FEED_M: begin
               dinfo_data <= snap_year;
               state      <= FEED_Y;
            end
            FEED_Y: begin
               dinfo_ena  <= 1'b0;
               dinfo_data <= 8'h00;
               state      <= CAPTURE;
            end
            CAPTURE: begin
               // BCD compares correctly as plain unsigned bytes
               day           <= dinfo_day;
               leap_year     <= dinfo_leap;
               days_in_month <= dinfo_dim;
               err           <= (snap_date > dinfo_dim) ? 2'b10 : 2'b00;
               done          <= 1'b1;
               busy          <= 1'b0;
               last_date     <= snap_date;
               last_month    <= snap_month;
               last_year     <= snap_year;
               state         <= IDLE;
            end
            default: begin
               dinfo_ena  <= 1'b0;
               dinfo_data <= 8'h00;
               busy       <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule
